i2c_master_ctrl: RTL and testbench

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

---
 rtl/i2c_master_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// I2C master for single-byte register writes and reads on one fixed slave.
// A write is START, address+W, register, data, STOP. A read is START,
// address+W, register, STOP, then START, address+R, one data byte, master
// NACK, STOP. The bus timebase is a quarter-period tick derived from clk.
module i2c_master_ctrl #(
  parameter int         CLK_DIV    = 4,
  parameter logic [6:0] SLAVE_ADDR = 7'b1010101,
  parameter int         AW         = 8,
  parameter int         DW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_rw,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          busy,
  output logic          done,
  output logic          ack_err,
  output logic [DW-1:0] rd_data,
  output logic          scl_o,
  output logic          sda_oe,
  input  logic          sda_i
);

  localparam int              DIVW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_A, REG, ACK_R, WDATA, ACK_W, STOP,
    RSTART, RADDR, ACK_RA, RDATA, MNACK, FINISH
  } state_t;

  state_t          state, state_next;
  logic [DIVW-1:0] div_cnt;
  logic [1:0]      quarter;
  logic [2:0]      bit_cnt;
  logic            rw_q;
  logic [7:0]      addr_byte;
  logic [7:0]      wdata_byte;
  logic            nack_q;
  logic            second_half;
  logic [7:0]      rx_shift;
  logic [7:0]      cur_byte;
  logic            accept, tick, phase_end, sample, scl_bit, tx_bit;
  logic            is_byte_state, is_ack_state;

  assign busy          = (state != IDLE) && (state != FINISH);
  assign cmd_ready     = ~busy;
  assign done          = (state == FINISH);
  assign accept        = cmd_valid && cmd_ready;
  assign tick          = busy && (div_cnt == DIV_LAST);
  assign phase_end     = tick && (quarter == 2'd3);
  assign sample        = tick && (quarter == 2'd2);
  assign scl_bit       = (quarter == 2'd1) || (quarter == 2'd2);
  assign is_byte_state = state inside {ADDR, REG, WDATA, RADDR, RDATA};
  assign is_ack_state  = state inside {ACK_A, ACK_R, ACK_W, ACK_RA};
  assign tx_bit        = cur_byte[3'd7 - bit_cnt];

  // Select the byte being shifted out in the current transmit phase
  always_comb begin
    cur_byte = 8'h00;
    case (state)
      ADDR:    cur_byte = {SLAVE_ADDR, 1'b0};
      REG:     cur_byte = addr_byte;
      WDATA:   cur_byte = wdata_byte;
      RADDR:   cur_byte = {SLAVE_ADDR, 1'b1};
      default: cur_byte = 8'h00;
    endcase
  end

  // State register; reset drops straight to IDLE without a STOP
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Quarter-period timebase, restarted from zero on every accepted command
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      quarter <= 2'd0;
    end else if (accept) begin
      div_cnt <= '0;
      quarter <= 2'd0;
    end else if (busy) begin
      if (tick) begin
        div_cnt <= '0;
        quarter <= quarter + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Bit position inside a byte; wraps back to 0 after the eighth bit
  always_ff @(posedge clk) begin
    if (rst || accept)                  bit_cnt <= 3'd0;
    else if (phase_end && is_byte_state) bit_cnt <= bit_cnt + 3'd1;
  end

  // Command capture, SDA sampling, NACK bookkeeping and read-data update
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q        <= 1'b0;
      addr_byte   <= 8'h00;
      wdata_byte  <= 8'h00;
      nack_q      <= 1'b0;
      second_half <= 1'b0;
      rx_shift    <= 8'h00;
      ack_err     <= 1'b0;
      rd_data     <= '0;
    end else begin
      if (accept) begin
        rw_q        <= cmd_rw;
        addr_byte   <= 8'(cmd_addr);
        wdata_byte  <= 8'(cmd_wdata);
        second_half <= 1'b0;
        ack_err     <= 1'b0;
      end
      if (sample) begin
        nack_q <= sda_i;
        if (state == RDATA) rx_shift <= {rx_shift[6:0], sda_i};
      end
      if (phase_end && is_ack_state && nack_q) ack_err <= 1'b1;
      if (state == RSTART) second_half <= 1'b1;
      if (phase_end && (state == STOP) && second_half && !ack_err)
        rd_data <= DW'(rx_shift);
    end
  end

  // Next-state sequencing and SCL/SDA levels for each phase quarter
  always_comb begin
    state_next = state;
    scl_o      = 1'b1;
    sda_oe     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = START;
      end
      START, RSTART: begin
        scl_o  = (quarter != 2'd3);
        sda_oe = (quarter != 2'd0);
        if (phase_end) state_next = (state == START) ? ADDR : RADDR;
      end
      ADDR, REG, WDATA, RADDR: begin
        scl_o  = scl_bit;
        sda_oe = ~tx_bit;
        if (phase_end && (bit_cnt == 3'd7)) begin
          if (state == ADDR)       state_next = ACK_A;
          else if (state == REG)   state_next = ACK_R;
          else if (state == WDATA) state_next = ACK_W;
          else                     state_next = ACK_RA;
        end
      end
      RDATA: begin
        scl_o = scl_bit;
        if (phase_end && (bit_cnt == 3'd7)) state_next = MNACK;
      end
      ACK_A, ACK_R, ACK_W, ACK_RA: begin
        scl_o = scl_bit;
        if (phase_end) begin
          if (nack_q)               state_next = STOP;
          else if (state == ACK_A)  state_next = REG;
          else if (state == ACK_R)  state_next = rw_q ? STOP : WDATA;
          else if (state == ACK_RA) state_next = RDATA;
          else                      state_next = STOP;
        end
      end
      MNACK: begin
        scl_o = scl_bit;
        if (phase_end) state_next = STOP;
      end
      STOP: begin
        scl_o  = (quarter != 2'd0);
        sda_oe = (quarter == 2'd0) || (quarter == 2'd1);
        if (phase_end)
          state_next = (rw_q && !second_half && !ack_err) ? RSTART : FINISH;
      end
      FINISH: begin
        state_next = accept ? START : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: a behavioural I2C slave watches the
// bus once per clk, logs every byte plus START/STOP, ACKs its own address
// and returns a fixed data byte on reads.
module tb_i2c_master_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ready, busy, done, ack_err;
  logic [7:0] rd_data;
  logic       scl_o, sda_oe, sda_i, sda_line;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;

  // Bus log: byte values, 256 marks START, 257 marks STOP
  int bus_log[$];

  logic [6:0] sl_addr = 7'h55;
  logic [7:0] sl_txbyte = 8'h5A;
  logic       sl_drive = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       sl_active = 1'b0;
  logic       sl_tx = 1'b0;
  logic       sl_inack = 1'b0;
  logic       sl_first = 1'b0;
  logic       sl_go_tx = 1'b0;
  logic       sl_mack = 1'b0;
  logic [3:0] sl_bits = 4'd0;
  logic [7:0] sl_shift = 8'h00;

  assign sda_line = ~(sda_oe | sl_drive);
  assign sda_i    = sda_line;

  i2c_master_ctrl #(
    .CLK_DIV(2), .SLAVE_ADDR(7'b1010101), .AW(8), .DW(8)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .busy(busy), .done(done), .ack_err(ack_err), .rd_data(rd_data),
    .scl_o(scl_o), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle counter, stable whenever the bench samples on the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  // Count done pulses so an aborted transaction can be shown to raise none
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // Behavioural slave: edge detection on SCL/SDA sampled every falling clk
  always @(negedge clk) begin
    prev_scl <= scl_o;
    prev_sda <= sda_line;
    if (prev_scl && scl_o && prev_sda && !sda_line) begin
      bus_log.push_back(256);
      sl_active <= 1'b1; sl_first <= 1'b1; sl_bits <= 4'd0;
      sl_tx <= 1'b0; sl_inack <= 1'b0; sl_go_tx <= 1'b0; sl_drive <= 1'b0;
    end else if (prev_scl && scl_o && !prev_sda && sda_line) begin
      bus_log.push_back(257);
      sl_active <= 1'b0; sl_tx <= 1'b0; sl_inack <= 1'b0; sl_drive <= 1'b0;
    end else if (sl_active && !prev_scl && scl_o) begin
      if (sl_inack) begin
        if (sl_tx) sl_mack <= sda_line;
      end else begin
        sl_shift <= {sl_shift[6:0], sda_line};
        sl_bits  <= sl_bits + 4'd1;
      end
    end else if (sl_active && prev_scl && !scl_o) begin
      if (sl_inack) begin
        sl_inack <= 1'b0;
        sl_bits  <= 4'd0;
        if (sl_go_tx) begin
          sl_tx <= 1'b1; sl_go_tx <= 1'b0; sl_drive <= ~sl_txbyte[7];
        end else if (sl_tx) begin
          sl_tx <= 1'b0; sl_active <= 1'b0; sl_drive <= 1'b0;
        end else begin
          sl_drive <= 1'b0;
        end
      end else if (sl_bits == 4'd8) begin
        bus_log.push_back(int'(sl_shift));
        sl_inack <= 1'b1;
        sl_first <= 1'b0;
        if (sl_tx) begin
          sl_drive <= 1'b0;
        end else if (sl_first) begin
          sl_drive <= (sl_shift[7:1] == sl_addr);
          sl_go_tx <= (sl_shift[7:1] == sl_addr) && sl_shift[0];
        end else begin
          sl_drive <= 1'b1;
        end
      end else if (sl_tx) begin
        sl_drive <= ~sl_txbyte[3'(4'd7 - sl_bits)];
      end
    end
  end

  // One comparison: counted, and reported on mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compare the bus log from index base against n expected entries
  task automatic checkLog(input string tag, input int base, input int exp_a[8], input int n);
    checkOutput({tag, "_len"}, bus_log.size() - base, n);
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_%0d", tag, i),
                  (base + i < bus_log.size()) ? bus_log[base + i] : -1, exp_a[i]);
  endtask

  // Present one command and hold it until the handshake cycle
  task automatic applyStimulus(input logic rw, input logic [7:0] addr,
                               input logic [7:0] wdata, output int acc_cyc);
    int waited = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wdata;
    @(negedge clk);
    while (!cmd_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    acc_cyc = cyc;
    checkOutput("accept_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Wait, bounded, for the done pulse
  task automatic waitDone(output int done_cyc);
    int waited = 0;
    @(negedge clk);
    while (!done && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    done_cyc = cyc;
    checkOutput("done_seen", done, 1);
  endtask

  // Directed sequence
  initial begin
    int a, d, d1, base, base2, snap;
    int exp_a[8];

    repeat (3) @(negedge clk);
    checkOutput("rst_scl", scl_o, 1);
    checkOutput("rst_sda_oe", sda_oe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ack_err", ack_err, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_scl", scl_o, 1);
    checkOutput("idle_sda_oe", sda_oe, 0);

    // Register write 0x3C <= 0xA5
    base = bus_log.size();
    applyStimulus(1'b0, 8'h3C, 8'hA5, a);
    waitDone(d);
    checkOutput("wr_latency", d - a, 233);
    checkOutput("wr_ack_err", ack_err, 0);
    checkOutput("wr_fin_ready", cmd_ready, 1);
    checkOutput("wr_fin_busy", busy, 0);
    checkOutput("wr_fin_scl", scl_o, 1);
    checkOutput("wr_fin_sda_oe", sda_oe, 0);
    exp_a = '{256, 'hAA, 'h3C, 'hA5, 257, 0, 0, 0};
    checkLog("wr_bus", base, exp_a, 5);
    @(negedge clk);
    checkOutput("wr_done_pulse", done, 0);

    // Register read 0x3C, slave returns 0x5A
    base = bus_log.size();
    applyStimulus(1'b1, 8'h3C, 8'h00, a);
    waitDone(d);
    checkOutput("rd_latency", d - a, 321);
    checkOutput("rd_ack_err", ack_err, 0);
    checkOutput("rd_data", rd_data, 8'h5A);
    checkOutput("rd_master_nack", sl_mack, 1);
    exp_a = '{256, 'hAA, 'h3C, 257, 256, 'hAB, 'h5A, 257};
    checkLog("rd_bus", base, exp_a, 8);

    // Slave answers to a different address: NACK on the address byte
    sl_addr = 7'h12;
    base = bus_log.size();
    applyStimulus(1'b1, 8'h3C, 8'h00, a);
    waitDone(d);
    checkOutput("nack_latency", d - a, 89);
    checkOutput("nack_ack_err", ack_err, 1);
    checkOutput("nack_rd_data", rd_data, 8'h5A);
    exp_a = '{256, 'hAA, 257, 0, 0, 0, 0, 0};
    checkLog("nack_bus", base, exp_a, 3);
    repeat (5) @(negedge clk);
    checkOutput("nack_err_held", ack_err, 1);
    sl_addr = 7'h55;

    // Back-to-back: cmd_valid stays high, fields change once the first is taken
    base = bus_log.size();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h10; cmd_wdata = 8'h77;
    @(negedge clk);
    a = cyc;
    checkOutput("b2b_ready1", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_addr = 8'h20; cmd_wdata = 8'h88;
    waitDone(d1);
    checkOutput("b2b_latency1", d1 - a, 233);
    checkOutput("b2b_fin_ready", cmd_ready, 1);
    exp_a = '{256, 'hAA, 'h10, 'h77, 257, 0, 0, 0};
    checkLog("b2b_bus1", base, exp_a, 5);
    base2 = bus_log.size();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_busy2", busy, 1);
    checkOutput("b2b_ack_err_clr", ack_err, 0);
    waitDone(d);
    checkOutput("b2b_latency2", d - d1, 233);
    exp_a = '{256, 'hAA, 'h20, 'h88, 257, 0, 0, 0};
    checkLog("b2b_bus2", base2, exp_a, 5);

    // A command pulsed while busy must be ignored
    base = bus_log.size();
    applyStimulus(1'b0, 8'h5C, 8'h3E, a);
    repeat (50) @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 8'hFF; cmd_wdata = 8'h00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    waitDone(d);
    checkOutput("ign_latency", d - a, 233);
    checkOutput("ign_ack_err", ack_err, 0);
    checkOutput("ign_rd_data", rd_data, 8'h5A);
    exp_a = '{256, 'hAA, 'h5C, 'h3E, 257, 0, 0, 0};
    checkLog("ign_bus", base, exp_a, 5);

    // Reset in the middle of the data byte
    applyStimulus(1'b0, 8'h3C, 8'hC3, a);
    repeat (172) @(negedge clk);
    checkOutput("mid_busy", busy, 1);
    snap = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_scl", scl_o, 1);
    checkOutput("abort_sda_oe", sda_oe, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ready", cmd_ready, 1);
    checkOutput("abort_rd_data", rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("abort_no_done", done_cnt, snap);

    // Recovery write after the abort
    base = bus_log.size();
    applyStimulus(1'b0, 8'h01, 8'hFF, a);
    waitDone(d);
    checkOutput("rec_latency", d - a, 233);
    exp_a = '{256, 'hAA, 'h01, 'hFF, 257, 0, 0, 0};
    checkLog("rec_bus", base, exp_a, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
